bm_expr_operand_stage: RTL and testbench
========================================

BM_EXPR_OPERAND_STAGE -- requirements
Module: bm_expr_operand_stage

Interface
REQ-001 The block SHALL have parameter BITS, default 32, giving the operand width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the FIFO entry count; DEPTH SHALL be a power of two and at least 2.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: `clock  input  1  rising-edge clock for all state`.
REQ-004 The block SHALL have `reset  input  1  synchronous active-high reset`.
REQ-005 The block SHALL have `flush  input  1  synchronous clear of queued operand pairs`.
REQ-006 The block SHALL have `in_valid  input  1  producer offers an operand pair`.
REQ-007 The block SHALL have `in_a  input  BITS  operand A`.
REQ-008 The block SHALL have `in_b  input  BITS  operand B`.
REQ-009 The block SHALL have `in_ready  output  1  block accepts a pair this cycle`.
REQ-010 The block SHALL have `out_valid  output  1  head pair available to the downstream expression stage`.
REQ-011 The block SHALL have `out_ready  input  1  downstream consumes the head pair`.
REQ-012 The block SHALL have `out_a  output  BITS  head operand A` and `out_b  output  BITS  head operand B`.
REQ-013 The block SHALL have `out_tag  output  8  sequence number of the head pair`.
REQ-014 The block SHALL have `count  output  log2(DEPTH)+1  occupancy`.
REQ-015 The block SHALL have `stall_cnt  output  16  saturating count of back-pressured cycles`.

Function
REQ-016 Push SHALL occur on a rising edge where in_valid=1, in_ready=1 and flush=0: {in_a, in_b, tag} are written at wr_ptr, wr_ptr increments modulo DEPTH, and tag increments.
REQ-017 Pop SHALL occur on a rising edge where out_valid=1, out_ready=1 and flush=0: rd_ptr increments modulo DEPTH.
REQ-018 in_ready SHALL equal (count < DEPTH) AND NOT reset AND NOT flush, combinationally from registered state.
REQ-019 out_valid SHALL equal (count != 0); out_a, out_b and out_tag SHALL show the entry at rd_ptr; their values are don't-care while out_valid=0.
REQ-020 Latency: a pair pushed at edge N SHALL be visible with out_valid=1 after edge N when the FIFO was empty; there is no same-cycle combinational pass-through from input to output.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle; no push is taken on that edge.
REQ-023 When empty, in_ready=1 and out_ready=1 SHALL pop nothing; only the push takes effect.
REQ-024 count SHALL be incremented by 1 on push-only, decremented by 1 on pop-only, and is otherwise unchanged.
REQ-025 The tag SHALL be 8 bits, start at 0 and wrap from 255 to 0; tag assignment SHALL follow push order.
REQ-026 Flush SHALL take priority over push and pop: it sets wr_ptr, rd_ptr and count to 0 on the edge, drops any offered pair, and preserves the tag counter and stall_cnt.
REQ-027 stall_cnt SHALL increment on each edge where in_valid=1 and in_ready=0 and flush=0, and SHALL saturate at 16'hFFFF.
REQ-028 Stored entries SHALL never be altered except by a push to that slot.

Reset
REQ-029 Reset SHALL take priority over flush and all traffic and SHALL set wr_ptr=0, rd_ptr=0, count=0, tag=0 and stall_cnt=0.
REQ-030 During and immediately after reset: out_valid=0; in_ready=0 while reset=1 and 1 on the first cycle after reset deasserts.
REQ-031 Reset asserted mid-stream SHALL discard all queued pairs; the first pair pushed after reset SHALL carry tag 0.
REQ-032 FIFO storage SHALL NOT require reset.

Verification
REQ-033 Single pair: after reset, push a=32'h0000_0005, b=32'h0000_0003 -> next cycle out_valid=1, out_a=5, out_b=3, out_tag=0, count=1; with out_ready=1, count returns to 0.
REQ-034 Fill/backpressure: push 5 pairs back-to-back with out_ready=0 -> in_ready drops after the 4th push, count=4; the 5th pair is held and stall_cnt increments each held cycle; raising out_ready drains pairs in order with tags 0..3, then 4.
REQ-035 Full with simultaneous pop: at count=4, in_valid=1 and out_ready=1 -> pop only, count=3; the pair is accepted on the following edge.
REQ-036 Tag wrap: stream 258 pairs with out_ready=1 -> out_tag sequence ends ...254, 255, 0, 1, with no gaps.
REQ-037 Flush vs push: at count=2, assert flush with in_valid=1 -> count=0, out_valid=0, pair dropped; the next push gets tag 2 (tag preserved).
REQ-038 Reset mid-operation: at count=3 and stall_cnt=7, pulse reset -> count=0, stall_cnt=0, out_valid=0; the next push yields out_tag=0.

Source files
------------

// File: rtl/bm_expr_operand_stage.sv
// rtl/bm_expr_operand_stage.sv - tagged operand-pair FIFO feeding the expression stage
// Each accepted pair carries an 8-bit sequence tag; flush empties the queue but keeps tag and stall history.
module bm_expr_operand_stage #(
  parameter int BITS  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [BITS-1:0]          in_a,
  input  logic [BITS-1:0]          in_b,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BITS-1:0]          out_a,
  output logic [BITS-1:0]          out_b,
  output logic [7:0]               out_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              stall_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [BITS-1:0] mem_a   [DEPTH];
  logic [BITS-1:0] mem_b   [DEPTH];
  logic [7:0]      mem_tag [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    tag;
  logic          push;
  logic          pop;
  logic          stall;

  // DEPTH is a power of two and count never exceeds it, so the MSB alone marks full.
  assign in_ready  = !count[AW] && !reset && !flush;
  assign out_valid = (count != '0);
  assign out_a     = mem_a[rd_ptr];
  assign out_b     = mem_b[rd_ptr];
  assign out_tag   = mem_tag[rd_ptr];

  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready && !flush;
  assign stall = in_valid && !in_ready && !flush;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_tag[wr_ptr] <= tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tag       <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        tag    <= tag + 8'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bm_expr_operand_stage.sv
// tb/tb_bm_expr_operand_stage.sv - self-checking bench for bm_expr_operand_stage
// A queue-based reference model tracks contents, tags and stall count.
module tb_bm_expr_operand_stage;

  localparam int BITS  = 32;
  localparam int DEPTH = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic [BITS-1:0] in_a = '0;
  logic [BITS-1:0] in_b = '0;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BITS-1:0] out_a;
  logic [BITS-1:0] out_b;
  logic [7:0]      out_tag;
  logic [2:0]      count;
  logic [15:0]     stall_cnt;

  bm_expr_operand_stage #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_tag(out_tag),
    .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [7:0]      tag;
  } ent_t;

  ent_t q[$];
  int   m_tag   = 0;
  int   m_stall = 0;
  int   n_cmp   = 0;
  int   n_fail  = 0;

  task automatic set_in(input logic v, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                        input logic ordy, input logic fl, input logic rst);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #1;
  endtask

  // Advance the model by the rules for the currently driven inputs, then clock the DUT.
  task automatic tick();
    bit   rdy;
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (reset) begin
      q.delete();
      m_tag   = 0;
      m_stall = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      rdy     = q.size() < DEPTH;
      do_pop  = (q.size() != 0) && out_ready;
      do_push = in_valid && rdy;
      if (in_valid && !rdy && m_stall < 65535) m_stall++;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.a = in_a; e.b = in_b; e.tag = 8'(m_tag);
        q.push_back(e);
        m_tag = (m_tag + 1) % 256;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, '0, '0, 0, 0, 1);
    tick();
    set_in(0, '0, '0, 0, 0, 0);
  endtask

  task automatic test_reset();
    set_in(1, 32'h1, 32'h2, 1, 0, 1);
    tick();
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    set_in(0, '0, '0, 0, 0, 0);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_single_pair();
    do_reset();
    set_in(1, 32'h5, 32'h3, 0, 0, 0);
    tick();
    set_in(0, '0, '0, 1, 0, 0);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_a !== 32'h5) begin n_fail++; $display("FAIL single_a got %0h want 5", out_a); end
    n_cmp++; if (out_b !== 32'h3) begin n_fail++; $display("FAIL single_b got %0h want 3", out_b); end
    n_cmp++; if (out_tag !== 8'd0) begin n_fail++; $display("FAIL single_tag got %0d want 0", out_tag); end
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
    tick();
    set_in(0, '0, '0, 0, 0, 0);
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_drain_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_fill_backpressure();
    logic [BITS-1:0] va [5];
    logic [BITS-1:0] vb [5];
    int got;
    bit pend;
    do_reset();
    for (int i = 0; i < 5; i++) begin va[i] = $urandom; vb[i] = $urandom; end
    for (int i = 0; i < 5; i++) begin
      set_in(1, va[i], vb[i], 0, 0, 0);
      n_cmp++; if (in_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_in_ready[%0d] got %0b want %0b", i, in_ready, i < 4); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1, va[4], vb[4], 0, 0, 0);
      tick();
    end
    set_in(1, va[4], vb[4], 0, 0, 0);
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", count); end
    n_cmp++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL fill_stall got %0d want 4", stall_cnt); end
    got  = 0;
    pend = 1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      set_in(pend, va[4], vb[4], 1, 0, 0);
      if (out_valid) begin
        n_cmp++; if (out_tag !== 8'(got) || out_a !== va[got] || out_b !== vb[got]) begin
          n_fail++; $display("FAIL drain_order[%0d] got tag %0d a %0h want tag %0d a %0h", got, out_tag, out_a, got, va[got]);
        end
        got++;
      end
      if (pend && in_ready) pend = 0;
      tick();
    end
    n_cmp++; if (got !== 5) begin n_fail++; $display("FAIL drain_total got %0d want 5", got); end
  endtask

  task automatic test_full_simul_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, $urandom, $urandom, 0, 0, 0);
      tick();
    end
    set_in(1, 32'hABCD, 32'h1234, 1, 0, 0);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_in_ready got %0b want 0", in_ready); end
    tick();
    set_in(1, 32'hABCD, 32'h1234, 0, 0, 0);
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL fullpop_count got %0d want 3", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_accept_ready got %0b want 1", in_ready); end
    tick();
    set_in(0, '0, '0, 0, 0, 0);
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fullpop_refill got %0d want 4", count); end
  endtask

  task automatic test_tag_wrap();
    int got;
    do_reset();
    got = 0;
    for (int c = 0; c < 300 && got < 258; c++) begin
      set_in(m_tag_pushes_left(got, c), $urandom, $urandom, 1, 0, 0);
      if (out_valid) begin
        n_cmp++; if (out_tag !== 8'(got % 256)) begin n_fail++; $display("FAIL wrap_tag[%0d] got %0d want %0d", got, out_tag, got % 256); end
        got++;
      end
      tick();
    end
    n_cmp++; if (got !== 258) begin n_fail++; $display("FAIL wrap_total got %0d want 258", got); end
  endtask

  function automatic logic m_tag_pushes_left(int popped, int cyc);
    return (cyc < 258);
  endfunction

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(1, $urandom, $urandom, 0, 0, 0);
      tick();
    end
    set_in(1, 32'hDEAD, 32'hBEEF, 0, 1, 0);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
    tick();
    set_in(1, 32'h77, 32'h88, 0, 0, 0);
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    tick();
    set_in(0, '0, '0, 0, 0, 0);
    n_cmp++; if (out_tag !== 8'd2 || out_a !== 32'h77) begin n_fail++; $display("FAIL flush_next_tag got tag %0d a %0h want tag 2 a 77", out_tag, out_a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, $urandom, $urandom, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      set_in(1, 32'h9, 32'h9, 0, 0, 0);
      tick();
    end
    set_in(0, '0, '0, 1, 0, 0);
    tick();
    set_in(0, '0, '0, 0, 0, 0);
    n_cmp++; if (count !== 3'd3 || stall_cnt !== 16'd7) begin n_fail++; $display("FAIL mid_setup got count %0d stall %0d want 3 7", count, stall_cnt); end
    set_in(1, 32'h1, 32'h1, 1, 0, 1);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready got %0b want 0", in_ready); end
    tick();
    set_in(1, 32'h42, 32'h43, 0, 0, 0);
    n_cmp++; if (count !== 3'd0 || stall_cnt !== 16'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_state got count %0d stall %0d valid %0b want 0 0 0", count, stall_cnt, out_valid);
    end
    tick();
    set_in(0, '0, '0, 0, 0, 0);
    n_cmp++; if (out_tag !== 8'd0 || out_a !== 32'h42) begin n_fail++; $display("FAIL mid_first_tag got tag %0d a %0h want 0 42", out_tag, out_a); end
  endtask

  task automatic test_random();
    bit exp_rdy;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      set_in(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 3) != 0,
             ($urandom % 32) == 0, ($urandom % 128) == 0);
      exp_rdy = !reset && !flush && (q.size() < DEPTH);
      n_cmp++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready[%0d] got %0b want %0b", c, in_ready, exp_rdy); end
      n_cmp++; if (count !== 3'(q.size()) || out_valid !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rand_count[%0d] got %0d/%0b want %0d", c, count, out_valid, q.size());
      end
      n_cmp++; if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL rand_stall[%0d] got %0d want %0d", c, stall_cnt, m_stall); end
      if (q.size() != 0) begin
        n_cmp++; if (out_a !== q[0].a || out_b !== q[0].b || out_tag !== q[0].tag) begin
          n_fail++; $display("FAIL rand_head[%0d] got %0h/%0h/%0d want %0h/%0h/%0d", c, out_a, out_b, out_tag, q[0].a, q[0].b, q[0].tag);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_fill_backpressure();
    test_full_simul_pop();
    test_tag_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
